// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: PC generator FSM states and default vectors.
package cpu_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } pc_state_t;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

endpackage

// File: rtl/redirect_latch.sv
// Holds redirect/trap requests that arrive while the PC cannot advance.
module redirect_latch
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_valid,
  input  logic [31:0] i_target,
  input  logic        i_trap,
  input  logic        i_consume,
  output logic        o_pend_redirect,
  output logic        o_pend_trap,
  output logic [31:0] o_target
);

  logic        r_pend_redirect;
  logic        r_pend_trap;
  logic [31:0] r_target;

  // A consuming advance takes live requests directly, so nothing new is stored then.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pend_redirect <= 1'b0;
      r_pend_trap     <= 1'b0;
      r_target        <= 32'h0;
    end else if (i_consume) begin
      r_pend_redirect <= 1'b0;
      r_pend_trap     <= 1'b0;
    end else begin
      if (i_trap)
        r_pend_trap <= 1'b1;
      if (i_valid) begin
        r_pend_redirect <= 1'b1;
        r_target        <= i_target;
      end
    end
  end

  assign o_pend_redirect = r_pend_redirect;
  assign o_pend_trap     = r_pend_trap;
  assign o_target        = r_target;

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: BOOT/RUN/HOLD FSM, PC register, trap/redirect priority.
// Optional feature macro: PC_MISALIGN_TRAP_EN (misaligned redirect targets trap).
module pc_gen
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        imem_ack,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        trap_valid,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic [31:0] pc_plus4
`ifdef PC_MISALIGN_TRAP_EN
  ,
  output logic        misaligned
`endif
);

  pc_state_t   r_state;
  pc_state_t   w_next_state;
  logic [31:0] r_pc;
  logic [31:0] w_next_pc;
  logic        w_advance;
  logic        w_live_redirect;
  logic        w_live_trap;
  logic        w_pend_redirect;
  logic        w_pend_trap;
  logic [31:0] w_pend_target;
  logic        w_redirect_req;
  logic [31:0] w_redirect_target;
  logic        w_trap_req;
  logic        w_take_trap;

  always_ff @(posedge clk) begin
    if (!reset_n)
      r_state <= BOOT;
    else
      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      BOOT:    w_next_state = RUN;
      RUN:     if (stall) w_next_state = HOLD;
      HOLD:    if (!stall) w_next_state = RUN;
      default: w_next_state = BOOT;
    endcase
  end

  // Requests are ignored while booting; a live redirect overrides a pending one.
  assign w_live_redirect   = redirect_valid && (r_state != BOOT);
  assign w_live_trap       = trap_valid && (r_state != BOOT);
  assign w_advance         = (r_state == RUN) && imem_ack && !stall;
  assign w_trap_req        = w_live_trap || w_pend_trap;
  assign w_redirect_req    = w_live_redirect || w_pend_redirect;
  assign w_redirect_target = w_live_redirect ? redirect_target : w_pend_target;

  redirect_latch u_latch (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_valid         (w_live_redirect),
    .i_target        (redirect_target),
    .i_trap          (w_live_trap),
    .i_consume       (w_advance),
    .o_pend_redirect (w_pend_redirect),
    .o_pend_trap     (w_pend_trap),
    .o_target        (w_pend_target)
  );

`ifdef PC_MISALIGN_TRAP_EN
  logic w_redirect_misaligned;
  logic r_misaligned;

  assign w_redirect_misaligned = w_redirect_req && (w_redirect_target[1:0] != 2'b00);
  assign w_take_trap           = w_trap_req || w_redirect_misaligned;

  always_ff @(posedge clk) begin
    if (!reset_n)
      r_misaligned <= 1'b0;
    else
      r_misaligned <= w_advance && !w_trap_req && w_redirect_misaligned;
  end

  assign misaligned = r_misaligned;
`else
  assign w_take_trap = w_trap_req;
`endif

  always_comb begin
    w_next_pc = pc_plus4;
    if (w_take_trap)
      w_next_pc = TRAP_VECTOR;
    else if (w_redirect_req)
      w_next_pc = w_redirect_target;
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      r_pc <= RESET_VECTOR;
    else if (w_advance)
      r_pc <= w_next_pc;
  end

  assign pc       = r_pc;
  assign pc_valid = (r_state != BOOT);
  assign pc_plus4 = r_pc + 32'd4;

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, PC loaded on reset.
REQ-002 Parameter TRAP_VECTOR, default 32'h0000_0100, PC loaded on trap.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 stall  input  1  downstream hold; PC SHALL NOT advance while high.
REQ-006 imem_ack  input  1  instruction memory has completed the fetch at pc.
REQ-007 redirect_valid  input  1  branch/jump redirect request, single-cycle pulse.
REQ-008 redirect_target  input  32  redirect destination PC.
REQ-009 trap_valid  input  1  trap request, single-cycle pulse.
REQ-010 pc  output  32  current fetch PC, consumed by fetch stage.
REQ-011 pc_valid  output  1  pc is a live fetch address.
REQ-012 pc_plus4  output  32  pc + 4, combinational from pc register.
REQ-013 misaligned  output  1  present only when PC_MISALIGN_TRAP_EN is defined.

Function
REQ-014 FSM states SHALL be BOOT, RUN, HOLD.
- BOOT: entered on reset, pc_valid=0, pc=RESET_VECTOR; SHALL go to RUN on the next cycle.
- RUN: pc_valid=1; goes to HOLD when stall=1.
- HOLD: pc_valid=1, pc frozen; returns to RUN when stall=0.
REQ-015 Advance event = state RUN, imem_ack=1, stall=0; pc SHALL update one cycle after the advance event, i.e. with one-cycle latency.
REQ-016 Next-PC priority at an advance event SHALL be: trap (live or pending) -> TRAP_VECTOR; else redirect (live or pending) -> target; else pc+4.
REQ-017 A redirect or trap arriving with no advance event SHALL be latched into a pending register, and pc SHALL be unchanged.
REQ-018 A later redirect SHALL overwrite a pending redirect target (last wins); a pending trap SHALL NOT be cleared by a redirect.
REQ-019 Pending trap and redirect flags SHALL clear on the advance event that consumes them.
REQ-020 Live redirect and trap together SHALL resolve as trap, and the redirect SHALL be discarded.
REQ-021 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000) with no flag.
REQ-022 imem_ack in BOOT or HOLD SHALL be ignored.
REQ-023 redirect_valid and trap_valid SHALL be latched in every state except BOOT, where they are ignored.

Reset
REQ-024 While reset_n=0 at a clock edge, the block SHALL force state=BOOT, pc=RESET_VECTOR, pc_valid=0, pending flags=0, and misaligned=0.
REQ-025 Reset asserted mid-operation, including with pending redirect/trap, SHALL discard all pending requests.

Configuration
REQ-026 Macro PC_MISALIGN_TRAP_EN applies.
- When defined, a redirect whose target has target[1:0]!=0 SHALL be treated as a trap: misaligned pulses high for one cycle at consumption and pc becomes TRAP_VECTOR.
- When undefined, the misaligned port and its logic SHALL be absent, and targets SHALL be used unmodified.

Structure
REQ-027 Shared package cpu_pkg SHALL hold the FSM state enum pc_state_t (BOOT, RUN, HOLD) and the default constants for RESET_VECTOR and TRAP_VECTOR.
REQ-028 The pending-redirect capture register SHALL be the sub-module redirect_latch (inputs: valid, target, trap, consume; outputs: pending flags, target); the PC register and FSM stay in pc_gen.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Reset release, imem_ack=1 constant, stall=0: cycle 1 BOOT pc=0 pc_valid=0, then pc = 0, 4, 8, 12 on consecutive cycles.
- Redirect pulse to 32'h40 with imem_ack=0 for 3 cycles, then ack: pc holds, then becomes 32'h40; pending clears.
- stall=1 for 2 cycles with imem_ack=1 at pc=32'h8: pc stays 32'h8 with pc_valid=1, state HOLD; after release, pc = 32'hC.
- Trap and redirect to 32'h80 in the same cycle with ack: pc becomes 32'h100 (TRAP_VECTOR).
- pc=32'hFFFF_FFFC, ack: pc becomes 32'h0.
- With PC_MISALIGN_TRAP_EN, redirect to 32'h42 with ack: misaligned=1 for one cycle, pc=32'h100. Without the macro, the same stimulus gives pc=32'h42.
